// File: rtl/sr_flag_arbiter_if.sv
// Requester-side bus of sr_flag_arbiter: per-requester req/{s,r} cmd/flag index, one-hot ack back.
interface sr_flag_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 3
);
  logic [N_REQ-1:0]       req;
  logic [2*N_REQ-1:0]     cmd;
  logic [IDX_W*N_REQ-1:0] idx;
  logic [N_REQ-1:0]       ack;

  modport master (output req, cmd, idx, input ack);
  modport slave  (input req, cmd, idx, output ack);
endinterface

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbitrated S/R flag bank; op latency 2 cycles (req seen in IDLE -> ack+flag update), one op per 3 cycles.
// Requesters hold req until ack; cmd 11 toggles when SR_FLAG_TOGGLE_EN is defined, otherwise it is flagged illegal.
module sr_flag_arbiter #(
  parameter int N_REQ   = 4,
  parameter int N_FLAGS = 8,
  parameter int IDX_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  sr_flag_arbiter_if.slave   bus,
  output logic [N_FLAGS-1:0] flags,
  output logic [N_FLAGS-1:0] flags_b,
  output logic               busy,
  output logic               err
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, ACK = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   win_q, win_d;
  logic [PTR_W-1:0]   cand;
  logic [1:0]         cmd_q, cmd_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [N_FLAGS-1:0] flags_q, flags_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               err_q, err_d;
  logic               found;
  logic               in_range;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    win_d    = win_q;
    cmd_d    = cmd_q;
    idx_d    = idx_q;
    flags_d  = flags_q;
    ack_d    = '0;
    err_d    = 1'b0;
    found    = 1'b0;
    cand     = '0;
    in_range = (int'(idx_q) < N_FLAGS);

    unique case (state_q)
      IDLE: begin
        // Search starts at rr_ptr so the last winner is the lowest priority.
        for (int k = 0; k < N_REQ; k++) begin
          cand = PTR_W'((int'(rr_ptr_q) + k) % N_REQ);
          if (!found && bus.req[cand]) begin
            found = 1'b1;
            win_d = cand;
          end
        end
        for (int j = 0; j < N_REQ; j++) begin
          if (found && (win_d == PTR_W'(j))) begin
            cmd_d = bus.cmd[2*j +: 2];
            idx_d = bus.idx[IDX_W*j +: IDX_W];
          end
        end
        if (found) state_d = GRANT;
      end
      GRANT: begin
        state_d      = ACK;
        ack_d[win_q] = 1'b1;
        rr_ptr_d     = (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;
        if (!in_range) begin
          err_d = 1'b1;
        end else begin
          unique case (cmd_q)
            2'b01: flags_d[idx_q] = 1'b0;
            2'b10: flags_d[idx_q] = 1'b1;
            2'b11: begin
`ifdef SR_FLAG_TOGGLE_EN
              flags_d[idx_q] = ~flags_q[idx_q];
`else
              err_d = 1'b1;
`endif
            end
            default: ;
          endcase
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      win_q    <= '0;
      cmd_q    <= 2'b00;
      idx_q    <= '0;
      flags_q  <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      win_q    <= win_d;
      cmd_q    <= cmd_d;
      idx_q    <= idx_d;
      flags_q  <= flags_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  assign bus.ack = ack_q;
  assign flags   = flags_q;
  assign flags_b = ~flags_q;
  assign busy    = (state_q != IDLE);
  assign err     = err_q;
endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Bench for sr_flag_arbiter (N_FLAGS=6): timeline model of issue/complete edges checked every cycle,
// plus directed scenarios with literal expectations.
module tb_sr_flag_arbiter;
  localparam int NR = 4;
  localparam int NF = 6;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NF-1:0] flags, flags_b;
  logic          busy, err;

  sr_flag_arbiter_if #(.N_REQ(NR), .IDX_W(IW)) bus ();

  sr_flag_arbiter #(.N_REQ(NR), .N_FLAGS(NF), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .flags(flags), .flags_b(flags_b), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: an op sampled at edge e completes (flag write, ack, err) at edge e+1; next sample allowed at e+3.
  int            m_edge, m_free_at, m_op_edge;
  bit            m_op_vld, m_found;
  logic [1:0]    m_ptr, m_w, m_cw;
  logic [1:0]    m_cmd;
  logic [2:0]    m_idx;
  logic [NF-1:0] m_flags, m_flags_b;
  logic [NR-1:0] m_ack;
  logic          m_err, m_busy;

  initial begin
    m_edge = 0; m_free_at = 0; m_op_edge = -10; m_op_vld = 0;
    m_ptr = 0; m_w = 0; m_cw = 0; m_cmd = 0; m_idx = 0; m_found = 0;
    m_flags = '0; m_flags_b = '1; m_ack = '0; m_err = 0; m_busy = 0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_op_vld = 0; m_op_edge = -10; m_free_at = 0; m_ptr = 0;
        m_flags = '0; m_ack = '0; m_err = 0; m_busy = 0;
      end else begin
        m_edge++;
        m_ack = '0;
        m_err = 0;
        if (m_op_vld && m_edge == m_op_edge + 1) begin
          m_op_vld = 0;
          m_ack = 4'b0001 << m_w;
          m_ptr = m_w + 2'd1;
          if (m_idx >= 3'(NF)) m_err = 1;
          else if (m_cmd == 2'b01) m_flags[m_idx] = 1'b0;
          else if (m_cmd == 2'b10) m_flags[m_idx] = 1'b1;
          else if (m_cmd == 2'b11) begin
`ifdef SR_FLAG_TOGGLE_EN
            m_flags[m_idx] = ~m_flags[m_idx];
`else
            m_err = 1;
`endif
          end
        end
        if (m_edge >= m_free_at && bus.req != '0) begin
          m_found = 0;
          for (int k = 0; k < NR; k++) begin
            m_cw = m_ptr + 2'(k);
            if (!m_found && bus.req[m_cw]) begin
              m_found = 1;
              m_w = m_cw;
            end
          end
          m_cmd = 2'(bus.cmd >> (2 * m_w));
          m_idx = 3'(bus.idx >> (3 * m_w));
          m_op_edge = m_edge;
          m_free_at = m_edge + 3;
          m_op_vld = 1;
        end
        m_busy = (m_edge == m_op_edge) || (m_edge == m_op_edge + 1);
      end
      m_flags_b = ~m_flags;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("cyc_flags",   flags,   m_flags);
      chk("cyc_flags_b", flags_b, m_flags_b);
      chk("cyc_ack",     bus.ack, m_ack);
      chk("cyc_busy",    busy,    m_busy);
      chk("cyc_err",     err,     m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] c, input logic [2:0] x);
    bus.cmd = (bus.cmd & ~(8'h03 << (2 * i))) | (8'(c) << (2 * i));
    bus.idx = (bus.idx & ~(12'h007 << (3 * i))) | (12'(x) << (3 * i));
    bus.req = bus.req | (4'b0001 << i);
  endtask

  task automatic drop_req(input int i);
    bus.req = bus.req & ~(4'b0001 << i);
  endtask

  task automatic wait_ack(input logic [NR-1:0] exp, input string nm, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (bus.ack == '0 && cnt < 12);
    chk(nm, bus.ack, exp);
  endtask

  task automatic reset_pulse();
    tick();
    bus.req = '0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Single-requester op; req dropped on the edge after ack.
  task automatic do_op(input int i, input logic [1:0] c, input logic [2:0] x,
                       input logic exp_err, input logic [NF-1:0] exp_flags, input string nm);
    int cnt;
    tick();
    set_req(i, c, x);
    wait_ack(4'b0001 << i, {nm, "_ack"}, cnt);
    chk({nm, "_err"}, err, exp_err);
    chk({nm, "_flags"}, flags, exp_flags);
    tick();
    drop_req(i);
  endtask

  logic [NF-1:0] tgl_flags;

  initial begin
    int cnt;
    bus.req = '0;
    bus.cmd = '0;
    bus.idx = '0;
    repeat (2) tick();
    chk("rst_flags", flags, 6'h00);
    chk("rst_flags_b", flags_b, 6'h3F);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ack", bus.ack, 4'b0000);
    rst = 1'b1;

    // Reset asserted during GRANT of a set to idx 2 aborts it.
    tick();
    set_req(2, 2'b10, 3'd2);
    tick();
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_flags", flags, 6'h00);
    chk("abort_flags_b", flags_b, 6'h3F);
    bus.req = '0;
    set_req(1, 2'b10, 3'd0);
    set_req(3, 2'b00, 3'd4);
    tick();
    tick();
    rst = 1'b1;
    wait_ack(4'b0010, "abort_first_ack", cnt);
    chk("abort_first_flags", flags, 6'h01);
    tick();
    drop_req(1);
    wait_ack(4'b1000, "abort_second_ack", cnt);
    chk("abort_second_flags", flags, 6'h01);
    tick();
    drop_req(3);

    // Single op, cycle-accurate.
    reset_pulse();
    tick();
    set_req(1, 2'b10, 3'd5);
    @(negedge clk);
    chk("single_t_busy", busy, 1'b0);
    @(negedge clk);
    chk("single_t1_busy", busy, 1'b1);
    chk("single_t1_ack", bus.ack, 4'b0000);
    @(negedge clk);
    chk("single_t2_ack", bus.ack, 4'b0010);
    chk("single_t2_flags", flags, 6'h20);
    chk("single_t2_busy", busy, 1'b1);
    tick();
    drop_req(1);
    @(negedge clk);
    chk("single_t3_ack", bus.ack, 4'b0000);
    chk("single_t3_busy", busy, 1'b0);

    // Round robin with all four held.
    reset_pulse();
    tick();
    for (int i = 0; i < NR; i++) set_req(i, 2'b10, 3'(i));
    wait_ack(4'b0001, "rr_ack0", cnt);
    wait_ack(4'b0010, "rr_ack1", cnt);
    chk("rr_gap1", cnt, 3);
    wait_ack(4'b0100, "rr_ack2", cnt);
    chk("rr_gap2", cnt, 3);
    wait_ack(4'b1000, "rr_ack3", cnt);
    chk("rr_gap3", cnt, 3);
    wait_ack(4'b0001, "rr_wrap_ack0", cnt);
    chk("rr_gap4", cnt, 3);
    tick();
    bus.req = '0;
    chk("rr_flags", flags, 6'h0F);

    // Opposite commands on the same flag: both serialized, later wins.
    reset_pulse();
    tick();
    set_req(0, 2'b10, 3'd3);
    set_req(1, 2'b01, 3'd3);
    wait_ack(4'b0001, "cont_ack0", cnt);
    chk("cont_flags_after0", flags, 6'h08);
    tick();
    drop_req(0);
    wait_ack(4'b0010, "cont_ack1", cnt);
    chk("cont_flags_after1", flags, 6'h00);
    tick();
    drop_req(1);

    // Illegal cmd, hold, out-of-range and last valid index.
    reset_pulse();
`ifdef SR_FLAG_TOGGLE_EN
    do_op(2, 2'b11, 3'd1, 1'b0, 6'h02, "cmd11");
    tgl_flags = 6'h02;
`else
    do_op(2, 2'b11, 3'd1, 1'b1, 6'h00, "cmd11");
    tgl_flags = 6'h00;
`endif
    do_op(1, 2'b00, 3'd1, 1'b0, tgl_flags, "hold");
    do_op(3, 2'b10, 3'd7, 1'b1, tgl_flags, "idx7");
    do_op(0, 2'b10, 3'd6, 1'b1, tgl_flags, "idx6");
    do_op(0, 2'b10, 3'd5, 1'b0, tgl_flags | 6'h20, "idx5");

    // req dropped and cmd/idx changed during GRANT: latched op still commits.
    reset_pulse();
    tick();
    set_req(0, 2'b10, 3'd4);
    tick();
    bus.req = '0;
    bus.cmd = '0;
    set_req(0, 2'b01, 3'd0);
    bus.req = '0;
    wait_ack(4'b0001, "gdrop_ack", cnt);
    chk("gdrop_flags", flags, 6'h10);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sr_flag_arbiter.md
Name: sr_flag_arbiter

Overview:
- Shared bank of N_FLAGS set/reset flags (qualified S/R flip-flop semantics) written by N_REQ independent requesters.
- Round-robin arbiter plus 3-state sequencer: grants one requester at a time, applies its {s,r} command to one flag, returns a one-cycle ack.
- Sits between control agents (e.g. interrupt sources, status writers) and the flag bank; resolves contention that a bare SR flip-flop cannot.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- N_FLAGS, 8, number of flags in the bank (1..64)
- IDX_W, 3, flag index width; must satisfy 2**IDX_W >= N_FLAGS

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset
- req  input  N_REQ  per-requester request; held high until ack
- cmd  input  2*N_REQ  per-requester {s,r}; slice i = cmd[2i+1:2i]
- idx  input  IDX_W*N_REQ  per-requester target flag index; slice i = idx[IDX_W*i +: IDX_W]
- ack  output  N_REQ  one-hot, one-cycle completion pulse
- flags  output  N_FLAGS  flag bank Q
- flags_b  output  N_FLAGS  always ~flags
- busy  output  1  high in GRANT and ACK states
- err  output  1  one-cycle pulse marking an illegal command or out-of-range index

Behaviour:
- Reset (rst low, async, any state): state=IDLE, flags=0, flags_b=all 1, ack=0, busy=0, err=0, rr_ptr=0. An in-flight op is aborted: no ack, no flag write.
- States:
  - IDLE: if any req bit is set, select winner = first set req at or after rr_ptr, wrapping N_REQ-1 -> 0. Latch winner, cmd and idx; go to GRANT. With no req, stay in IDLE.
  - GRANT: always go to ACK. On this edge:
    - Apply the latched cmd to flags[idx].
    - Register ack[winner]=1.
    - Set rr_ptr = winner+1, wrapping to 0.
  - ACK: ack[winner] high for exactly this cycle; go to IDLE.
- Command encoding {s,r}:
  - 00: hold (still acked).
  - 01: clear flag to 0.
  - 10: set flag to 1.
  - 11: see Optional Feature. Never produces X/Z on flags.
- Out-of-range idx (idx >= N_FLAGS): no flag write; ack still issued; err pulses in ACK.
- Latency: req sampled in IDLE at cycle t; flag updated and ack visible at t+2. Back-to-back throughput is one op per 3 cycles.
- Requester protocol:
  - Hold req, cmd and idx stable until ack is seen.
  - Drop req on the edge after ack. A still-high req in the following IDLE cycle is a new request.
- cmd/idx are latched in IDLE; changes during GRANT/ACK are ignored.
- If req drops during GRANT, the op still commits and is acked.
- Simultaneous requests to the same flag with opposite commands are serialized by round-robin. The later op wins the final value; neither is dropped.
- Fairness: a continuously requesting agent waits at most N_REQ-1 other ops.
- flags_b is combinational ~flags and always complementary.

Optional Feature:
- Macro SR_FLAG_TOGGLE_EN.
- Defined: cmd 11 toggles flags[idx] (JK behaviour); err is not asserted.
- Undefined: cmd 11 is illegal; flag unchanged, ack issued, err pulses in ACK.

Test Plan:
- Reset: drive rst=0 mid-GRANT of a set to idx 2 -> flags=0x00, flags_b=0xFF, no ack, rr_ptr=0; after release, first op goes to the lowest set req.
- Single op: req[1]=1, cmd=10, idx=5 at t -> flags=0x20 and ack=0010 at t+2 for one cycle; busy high at t+1 and t+2.
- Round-robin: req=1111 held, all cmd=10, idx=i -> acks in order 0,1,2,3 every 3 cycles, then wrap to 0; final flags=0x0F.
- Contention: req0 cmd=10 idx=3 and req1 cmd=01 idx=3 in the same cycle, rr_ptr=0 -> flags[3]=1 after ack0, 0 after ack1; both acked.
- Illegal/range (N_FLAGS=6): cmd=11 idx=1 without the macro -> flag unchanged, err pulse; with the macro -> flags[1] toggles, err=0. idx=7 -> no write, err pulse, ack issued.
